// File: rtl/wb_pkg.sv
// Shared writeback definitions: register/word widths, zero constants and the
// write-source selector used by the writeback arbiter.
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    localparam logic [REG_AW-1:0] ZEROREG  = 5'd0;
    localparam logic [XLEN-1:0]   ZEROWORD = 32'd0;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result buffer: DEPTH-entry FIFO with wrap-bit pointers. With WB_BYPASS_EN
// defined it also exposes every entry plus write pointer and fill count.
module wb_ld_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [REG_AW-1:0]       push_rd,
    input  logic [XLEN-1:0]         push_data,
    output logic                    full,
    output logic                    empty,
    output logic [REG_AW-1:0]       head_rd,
    output logic [XLEN-1:0]         head_data
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH*REG_AW-1:0] ent_rd,
    output logic [DEPTH*XLEN-1:0]   ent_data,
    output logic [AW:0]             wr_ptr,
    output logic [AW:0]             count
`endif
);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [REG_AW-1:0]  rd_mem_q [DEPTH];
    logic [REG_AW-1:0]  rd_mem_d [DEPTH];
    logic [XLEN-1:0]    data_mem_q [DEPTH];
    logic [XLEN-1:0]    data_mem_d [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A push into a full buffer is only legal when the head leaves that cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_rd   = rd_mem_q[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];

`ifdef WB_BYPASS_EN
    assign wr_ptr = wr_ptr_q;
    assign count  = wr_ptr_q - rd_ptr_q;
    for (genvar g = 0; g < DEPTH; g++) begin : g_readout
        assign ent_rd[g*REG_AW +: REG_AW] = rd_mem_q[g];
        assign ent_data[g*XLEN +: XLEN]   = data_mem_q[g];
    end
`endif

    // Next pointer and storage state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (do_push) begin
            rd_mem_d[wr_ptr_q[AW-1:0]]   = push_rd;
            data_mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                     = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= ZEROREG;
                data_mem_q[i] <= ZEROWORD;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback arbiter: merges ALU and buffered load results onto one registered
// register-file write port and tracks pending writes. Optional lookup: WB_BYPASS_EN.
module wb_writer
    import wb_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        RegWrite,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data,
    output logic [31:0] busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_rs,
    output logic        byp_hit,
    output logic [31:0] byp_data
`endif
);

    localparam int AW = $clog2(LD_DEPTH);

    logic              ld_full, ld_empty, ld_push, ld_pop;
    logic [REG_AW-1:0] ld_head_rd;
    logic [XLEN-1:0]   ld_head_data;
    wb_src_e           win_src;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [XLEN-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   clr_mask, set_mask;

`ifdef WB_BYPASS_EN
    logic [LD_DEPTH*REG_AW-1:0] ent_rd;
    logic [LD_DEPTH*XLEN-1:0]   ent_data;
    logic [AW:0]                fifo_wr_ptr;
    logic [AW:0]                fifo_count;
`endif

    // Both channels stall while the buffer is full so the head can drain.
    assign alu_ready = rst_n && !ld_full;
    assign ld_ready  = rst_n && !ld_full;
    assign ld_push   = ld_valid && ld_ready;
    assign ld_pop    = (win_src == LD);

    wb_ld_fifo #(.DEPTH(LD_DEPTH), .AW(AW)) u_ld_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_push),
        .pop       (ld_pop),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .full      (ld_full),
        .empty     (ld_empty),
        .head_rd   (ld_head_rd),
        .head_data (ld_head_data)
`ifdef WB_BYPASS_EN
        ,
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .wr_ptr    (fifo_wr_ptr),
        .count     (fifo_count)
`endif
    );

    // Pick this cycle's writer and compute the registered write-port state.
    always_comb begin
        win_src  = NONE;
        win_rd   = ZEROREG;
        win_data = ZEROWORD;
        if (!rst_n) begin
            win_src = NONE;
        end else if (ld_full) begin
            win_src = LD;
        end else if (alu_valid) begin
            win_src = ALU;
        end else if (!ld_empty) begin
            win_src = LD;
        end else begin
            win_src = NONE;
        end
        case (win_src)
            ALU: begin
                win_rd   = alu_rd;
                win_data = alu_data;
            end
            LD: begin
                win_rd   = ld_head_rd;
                win_data = ld_head_data;
            end
            default: begin
                win_rd   = ZEROREG;
                win_data = ZEROWORD;
            end
        endcase
        // Writes to x0 are consumed but never reach the register file.
        regwrite_d = (win_src != NONE) && (win_rd != ZEROREG);
        rd_d       = regwrite_d ? win_rd   : rd_q;
        wr_data_d  = regwrite_d ? win_data : wr_data_q;
        // Set is applied after clear so a same-register reissue stays pending.
        clr_mask   = regwrite_q ? (32'd1 << rd_q) : ZEROWORD;
        set_mask   = (iss_valid && (iss_rd != ZEROREG)) ? (32'd1 << iss_rd) : ZEROWORD;
        busy_d     = (busy_q & ~clr_mask) | set_mask;
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            rd_q       <= ZEROREG;
            wr_data_q  <= ZEROWORD;
            busy_q     <= ZEROWORD;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign Rd       = rd_q;
    assign Wr_data  = wr_data_q;
    assign busy     = busy_q;

`ifdef WB_BYPASS_EN
    logic              byp_found;
    logic [AW-1:0]     byp_idx;

    // Newest-first lookup: the write port, then buffer entries youngest to oldest.
    always_comb begin
        byp_hit   = 1'b0;
        byp_data  = ZEROWORD;
        byp_found = 1'b0;
        byp_idx   = {AW{1'b0}};
        if (byp_rs == ZEROREG) begin
            byp_hit  = 1'b0;
            byp_data = ZEROWORD;
        end else if (regwrite_q && (rd_q == byp_rs)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data_q;
        end else begin
            for (int k = 0; k < LD_DEPTH; k++) begin
                byp_idx = fifo_wr_ptr[AW-1:0] - AW'(k + 1);
                if (!byp_found && ((AW+1)'(k) < fifo_count) &&
                    (ent_rd[int'(byp_idx)*REG_AW +: REG_AW] == byp_rs)) begin
                    byp_found = 1'b1;
                    byp_hit   = 1'b1;
                    byp_data  = ent_data[int'(byp_idx)*XLEN +: XLEN];
                end else begin
                    byp_found = byp_found;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios with a write scoreboard.
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
    logic [31:0] busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    always #5 clk = ~clk;

    wb_writer #(.LD_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .RegWrite  (RegWrite),
        .Rd        (Rd),
        .Wr_data   (Wr_data),
        .busy      (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs    (byp_rs),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        iss_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Every register-file write must match the next scoreboard entry, in order.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", {27'd0, Rd}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_rd", {27'd0, Rd}, {27'd0, e.rd});
                    chk("wr_data", Wr_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
`ifdef WB_BYPASS_EN
        byp_rs    = 5'd0;
`endif
        tick(); tick();
        @(negedge clk);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_rd", {27'd0, Rd}, 32'd0);
        chk("rst_wdata", Wr_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("alu_ready_idle", {31'd0, alu_ready}, 32'd1);
        chk("ld_ready_idle", {31'd0, ld_ready}, 32'd1);

        // ALU only, one-cycle latency, then hold with RegWrite low
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        expect_wr(5'd5, 32'h1234_5678);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_lat_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("alu_lat_rd", {27'd0, Rd}, 32'd5);
        tick();
        @(negedge clk);
        chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("idle_rd_hold", {27'd0, Rd}, 32'd5);
        chk("idle_wdata_hold", Wr_data, 32'h1234_5678);

        // Contention with empty buffer: ALU first, load the cycle after
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3A3_0003;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hB4B4_0004;
        expect_wr(5'd3, 32'hA3A3_0003);
        expect_wr(5'd4, 32'hB4B4_0004);
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        chk("cont_first_rd", {27'd0, Rd}, 32'd3);
        tick();
        @(negedge clk);
        chk("cont_second_rd", {27'd0, Rd}, 32'd4);
        chk("cont_second_we", {31'd0, RegWrite}, 32'd1);
        idle(2);

        // Write to x0 is accepted but dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("x0_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("x0_wdata_hold", Wr_data, 32'hB4B4_0004);
        idle(1);

        // Buffer fills behind an ALU stream, head drains and ALU resumes
        expect_wr(5'd10, 32'h0000_0010);
        expect_wr(5'd11, 32'h0000_0011);
        expect_wr(5'd6,  32'h6666_0006);
        expect_wr(5'd12, 32'h0000_0012);
        expect_wr(5'd7,  32'h7777_0007);
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0010;
        ld_valid  = 1'b1; ld_rd  = 5'd6;  ld_data  = 32'h6666_0006;
        tick();
        alu_rd = 5'd11; alu_data = 32'h0000_0011;
        ld_rd  = 5'd7;  ld_data  = 32'h7777_0007;
        tick();
        ld_valid = 1'b0;
        alu_rd = 5'd12; alu_data = 32'h0000_0012;
        @(negedge clk);
        chk("full_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("drain_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        idle(3);

        // Scoreboard: reissue during writeback keeps the bit set
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("busy9_set", {31'd0, busy[9]}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
        expect_wr(5'd9, 32'h9999_0009);
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("busy9_set_prio", {31'd0, busy[9]}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0019;
        expect_wr(5'd9, 32'h9999_0019);
        tick();
        alu_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("busy9_clear", {31'd0, busy[9]}, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("busy0_ignored", busy, 32'd0);

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020_0020;
        expect_wr(5'd20, 32'h2020_0020);
        tick();
        alu_valid = 1'b0;
        byp_rs = 5'd20;
        @(negedge clk);
        chk("byp_hit", {31'd0, byp_hit}, 32'd1);
        chk("byp_data", byp_data, 32'h2020_0020);
        byp_rs = 5'd0;
        #1;
        chk("byp_x0", {31'd0, byp_hit}, 32'd0);
        idle(1);
`endif

        // Reset with two loads buffered discards them and clears the scoreboard
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        expect_wr(5'd13, 32'h0000_0013);
        expect_wr(5'd14, 32'h0000_0014);
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h0000_0013;
        ld_valid  = 1'b1; ld_rd  = 5'd8;  ld_data  = 32'h8888_0008;
        tick();
        alu_rd = 5'd14; alu_data = 32'h0000_0014;
        ld_rd  = 5'd9;  ld_data  = 32'h9999_0099;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy & 32'h0000_0300, 32'h0000_0300);
        chk("in_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("in_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 32'd0);
        chk("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        idle(6);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
